// File: rtl/reg_bank_16x16.sv
// Sixteen-entry general-purpose register bank with status flags and a saturating
// count of committed writes. All registers are exposed in parallel for the downstream operand muxes.
module reg_bank_16x16 #(
  parameter int WIDTH  = 16,
  parameter int FLAG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              clr,
  input  logic              flag_en,
  input  logic [FLAG_W-1:0] flags_in,
  output logic [WIDTH-1:0]  r0,
  output logic [WIDTH-1:0]  r1,
  output logic [WIDTH-1:0]  r2,
  output logic [WIDTH-1:0]  r3,
  output logic [WIDTH-1:0]  r4,
  output logic [WIDTH-1:0]  r5,
  output logic [WIDTH-1:0]  r6,
  output logic [WIDTH-1:0]  r7,
  output logic [WIDTH-1:0]  r8,
  output logic [WIDTH-1:0]  r9,
  output logic [WIDTH-1:0]  r10,
  output logic [WIDTH-1:0]  r11,
  output logic [WIDTH-1:0]  r12,
  output logic [WIDTH-1:0]  r13,
  output logic [WIDTH-1:0]  r14,
  output logic [WIDTH-1:0]  r15,
  output logic [FLAG_W-1:0] flags,
  output logic [15:0]       wr_count
);

  logic [WIDTH-1:0]  r_regs [16];
  logic [FLAG_W-1:0] r_flags;
  logic [15:0]       r_wr_count;
  logic              w_commit;

  // Clear wins over a simultaneous write; the discarded write is not counted.
  assign w_commit = wr_en && !clr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        r_regs[i] <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < 16; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_commit) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= '0;
    end else if (flag_en) begin
      r_flags <= flags_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_count <= '0;
    end else if (w_commit && (r_wr_count != 16'hFFFF)) begin
      r_wr_count <= r_wr_count + 16'd1;
    end
  end

  assign r0       = r_regs[0];
  assign r1       = r_regs[1];
  assign r2       = r_regs[2];
  assign r3       = r_regs[3];
  assign r4       = r_regs[4];
  assign r5       = r_regs[5];
  assign r6       = r_regs[6];
  assign r7       = r_regs[7];
  assign r8       = r_regs[8];
  assign r9       = r_regs[9];
  assign r10      = r_regs[10];
  assign r11      = r_regs[11];
  assign r12      = r_regs[12];
  assign r13      = r_regs[13];
  assign r14      = r_regs[14];
  assign r15      = r_regs[15];
  assign flags    = r_flags;
  assign wr_count = r_wr_count;

endmodule
